// File: rtl/nukv_pred_pkg.sv
// Shared constants and FSM encoding for the predicate assembler.
package nukv_pred_pkg;

    localparam int PRED_SLOT_WIDTH = 48;
    localparam int PRED_MAX_DEPTH  = 9;
    localparam int CFG_SCAN_BIT    = 63;
    localparam int CFG_COUNT_LSB   = 56;
    localparam int CFG_COUNT_W     = 4;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_META,
        ST_PRED,
        ST_WAIT_LAST,
        ST_OUT
    } asm_state_e;

endpackage

// File: rtl/nukv_predicate_assembler.sv
// Packs a narrow config packet into {predicates, meta} for the evaluation pipeline.
// Optional statistics counters are enabled by defining NUKV_PRED_ASM_STATS_EN.
module nukv_predicate_assembler
    import nukv_pred_pkg::*;
#(
    parameter int MEMORY_WIDTH = 512,
    parameter int META_WIDTH   = 96,
    parameter int PIPE_DEPTH   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [63:0]                    cfg_data,
    input  logic                           cfg_valid,
    input  logic                           cfg_last,
    output logic                           cfg_ready,
    output logic [META_WIDTH+MEMORY_WIDTH-1:0] pred_data,
    output logic                           pred_valid,
    output logic                           pred_scan,
    input  logic                           pred_ready,
    output logic                           error_input,
    output logic [31:0]                    stat_pkts,
    output logic [31:0]                    stat_errs
);

    asm_state_e                  state;
    logic [META_WIDTH-1:0]       meta_q;
    logic [PRED_SLOT_WIDTH-1:0]  slot_q [PIPE_DEPTH];
    logic [CFG_COUNT_W-1:0]      count_q;
    logic [CFG_COUNT_W-1:0]      pidx_q;
    logic                        scan_q;
    logic                        err_q;
    logic                        pred_valid_q;
    logic                        error_q;

    logic                        accept;
    logic [CFG_COUNT_W-1:0]      hdr_count;
    logic [CFG_COUNT_W-1:0]      count_sat;
    logic                        count_over;
    logic [PRED_MAX_DEPTH-1:0]   slot_en;
    logic                        over_depth;
    logic                        last_pred;
    logic                        pred_err;
    logic                        unused_cfg_bits;

    assign cfg_ready   = (state != ST_OUT);
    assign accept      = cfg_valid & cfg_ready;
    assign pred_valid  = pred_valid_q;
    assign pred_scan   = scan_q;
    assign error_input = error_q;

    assign hdr_count  = cfg_data[CFG_COUNT_LSB +: CFG_COUNT_W];
    assign count_over = (hdr_count > CFG_COUNT_W'(PRED_MAX_DEPTH));
    assign count_sat  = count_over ? CFG_COUNT_W'(PRED_MAX_DEPTH) : hdr_count;
    assign last_pred  = (CFG_COUNT_W'(pidx_q + 1'b1) == count_q);
    assign pred_err   = err_q | over_depth;

    assign unused_cfg_bits = ^{cfg_data[62:60], cfg_data[55:48]};

    // One-hot slot decode; the slots past PIPE_DEPTH only feed the overflow flag.
    always_comb begin
        slot_en    = '0;
        over_depth = 1'b0;
        for (int unsigned k = 0; k < PRED_MAX_DEPTH; k++)
            slot_en[k] = (pidx_q == CFG_COUNT_W'(k));
        for (int unsigned k = PIPE_DEPTH; k < PRED_MAX_DEPTH; k++)
            over_depth = over_depth | slot_en[k];
    end

    always_comb begin
        pred_data = '0;
        pred_data[META_WIDTH-1:0] = meta_q;
        for (int unsigned k = 0; k < PIPE_DEPTH; k++)
            pred_data[META_WIDTH + k*PRED_SLOT_WIDTH +: PRED_SLOT_WIDTH] = slot_q[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_HDR;
            meta_q       <= '0;
            count_q      <= '0;
            pidx_q       <= '0;
            scan_q       <= 1'b0;
            err_q        <= 1'b0;
            pred_valid_q <= 1'b0;
            error_q      <= 1'b0;
            for (int unsigned k = 0; k < PIPE_DEPTH; k++)
                slot_q[k] <= '0;
        end else begin
            error_q <= 1'b0;
            case (state)
                ST_HDR: if (accept) begin
                    scan_q  <= cfg_data[CFG_SCAN_BIT];
                    count_q <= count_sat;
                    meta_q  <= {cfg_data[31:0], 64'd0};
                    pidx_q  <= '0;
                    err_q   <= count_over;
                    for (int unsigned k = 0; k < PIPE_DEPTH; k++)
                        slot_q[k] <= '0;
                    if (cfg_last) begin
                        state        <= ST_OUT;
                        pred_valid_q <= 1'b1;
                        error_q      <= 1'b1;
                    end else begin
                        state <= ST_META;
                    end
                end
                ST_META: if (accept) begin
                    meta_q[63:0] <= cfg_data;
                    if (cfg_last) begin
                        state        <= ST_OUT;
                        pred_valid_q <= 1'b1;
                        error_q      <= err_q | (count_q != '0);
                    end else if (count_q != '0) begin
                        state <= ST_PRED;
                    end else begin
                        state <= ST_WAIT_LAST;
                    end
                end
                ST_PRED: if (accept) begin
                    for (int unsigned k = 0; k < PIPE_DEPTH; k++)
                        if (slot_en[k]) slot_q[k] <= cfg_data[PRED_SLOT_WIDTH-1:0];
                    pidx_q <= pidx_q + 1'b1;
                    err_q  <= pred_err;
                    // A short packet is flagged here; an on-count last closes cleanly.
                    if (cfg_last) begin
                        state        <= ST_OUT;
                        pred_valid_q <= 1'b1;
                        error_q      <= pred_err | ~last_pred;
                    end else if (last_pred) begin
                        state <= ST_WAIT_LAST;
                    end
                end
                ST_WAIT_LAST: if (accept) begin
                    err_q <= 1'b1;
                    if (cfg_last) begin
                        state        <= ST_OUT;
                        pred_valid_q <= 1'b1;
                        error_q      <= 1'b1;
                    end
                end
                ST_OUT: if (pred_ready) begin
                    pred_valid_q <= 1'b0;
                    state        <= ST_HDR;
                end
                default: state <= ST_HDR;
            endcase
        end
    end

`ifdef NUKV_PRED_ASM_STATS_EN
    logic [31:0] stat_pkts_q;
    logic [31:0] stat_errs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts_q <= '0;
            stat_errs_q <= '0;
        end else begin
            if (pred_valid_q && pred_ready) stat_pkts_q <= stat_pkts_q + 32'd1;
            if (error_q)                    stat_errs_q <= stat_errs_q + 32'd1;
        end
    end

    assign stat_pkts = stat_pkts_q;
    assign stat_errs = stat_errs_q;
`else
    assign stat_pkts = '0;
    assign stat_errs = '0;
`endif

endmodule

// File: tb/tb_nukv_predicate_assembler.sv
// Directed scoreboard bench: two assemblers (PIPE_DEPTH 2 and 1) share one config stream.
module tb_nukv_predicate_assembler;

    localparam int W = 608;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   cfg_data = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_last = 1'b0;
    logic          pred_ready = 1'b0;

    logic          cfg_ready2, cfg_ready1;
    logic [W-1:0]  pred_data2, pred_data1;
    logic          pred_valid2, pred_valid1;
    logic          pred_scan2, pred_scan1;
    logic          error_input2, error_input1;
    logic [31:0]   stat_pkts2, stat_errs2, stat_pkts1, stat_errs1;

    int vectors = 0;
    int fails   = 0;
    int pkts_exp = 0;
    int errs2_exp = 0;
    int errs1_exp = 0;

    typedef struct {
        logic [W-1:0] d2;
        logic [W-1:0] d1;
        logic         scan;
        logic         e2;
        logic         e1;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    nukv_predicate_assembler #(.MEMORY_WIDTH(512), .META_WIDTH(96), .PIPE_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_last(cfg_last),
        .cfg_ready(cfg_ready2), .pred_data(pred_data2), .pred_valid(pred_valid2),
        .pred_scan(pred_scan2), .pred_ready(pred_ready), .error_input(error_input2),
        .stat_pkts(stat_pkts2), .stat_errs(stat_errs2));

    nukv_predicate_assembler #(.MEMORY_WIDTH(512), .META_WIDTH(96), .PIPE_DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_last(cfg_last),
        .cfg_ready(cfg_ready1), .pred_data(pred_data1), .pred_valid(pred_valid1),
        .pred_scan(pred_scan1), .pred_ready(pred_ready), .error_input(error_input1),
        .stat_pkts(stat_pkts1), .stat_errs(stat_errs1));

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] hdr(input logic scan, input logic [3:0] cnt, input logic [31:0] mh);
        return {scan, 3'b000, cnt, 24'd0, mh};
    endfunction

    // Reference packing written from the packet format, independent of the FSM.
    function automatic void model(input logic [63:0] b[$], input int depth,
                                  output logic [W-1:0] d, output logic err);
        int n, cnt, ce;
        n   = b.size();
        d   = '0;
        cnt = int'(b[0][59:56]);
        err = (cnt > 9);
        ce  = (cnt > 9) ? 9 : cnt;
        d[95:64] = b[0][31:0];
        if (n == 1) begin
            err = 1'b1;
            return;
        end
        d[63:0] = b[1];
        if (n == 2) begin
            if (cnt > 0) err = 1'b1;
            return;
        end
        for (int i = 0; i < n - 2; i++) begin
            if (i < ce) begin
                if (i < depth) d[96 + i*48 +: 48] = b[i+2][47:0];
                else           err = 1'b1;
            end else begin
                err = 1'b1;
            end
        end
        if (n - 2 < ce) err = 1'b1;
    endfunction

    task automatic drive_beat(input logic [63:0] data, input logic last);
        int t;
        @(negedge clk);
        cfg_data  = data;
        cfg_valid = 1'b1;
        cfg_last  = last;
        t = 0;
        while (!cfg_ready2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("cfg_ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic send(input logic [63:0] b[$]);
        exp_t e;
        model(b, 2, e.d2, e.e2);
        model(b, 1, e.d1, e.e1);
        e.scan = b[0][63];
        sb.push_back(e);
        for (int i = 0; i < b.size(); i++)
            drive_beat(b[i], (i == b.size() - 1));
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int t;
        logic stable;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1'b1, 1'b0);
            return;
        end
        e = sb.pop_front();
        t = 0;
        while (!pred_valid2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_latency"}, W'(t), W'(0));
        chk({tag, "_valid"}, {pred_valid2, pred_valid1}, 2'b11);
        chk({tag, "_err"}, {error_input2, error_input1}, {e.e2, e.e1});
        chk({tag, "_data_d2"}, pred_data2, e.d2);
        chk({tag, "_data_d1"}, pred_data1, e.d1);
        chk({tag, "_scan"}, {pred_scan2, pred_scan1}, {e.scan, e.scan});
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (pred_valid2 !== 1'b1 || pred_data2 !== e.d2 || pred_data1 !== e.d1 ||
                    cfg_ready2 !== 1'b0 || cfg_ready1 !== 1'b0 || error_input2 !== 1'b0)
                    stable = 1'b0;
            end
            chk({tag, "_hold_stable"}, stable, 1'b1);
        end
        pred_ready = 1'b1;
        @(negedge clk);
        pred_ready = 1'b0;
        pkts_exp++;
        if (e.e2) errs2_exp++;
        if (e.e1) errs1_exp++;
        chk({tag, "_released"}, {pred_valid2, pred_valid1, cfg_ready2, cfg_ready1}, 4'b0011);
    endtask

    initial begin
        logic [63:0] pk[$];

        repeat (3) @(negedge clk);
        chk("reset_outputs", {pred_valid2, error_input2, pred_scan2, pred_valid1, error_input1}, 5'b0);
        chk("reset_data", pred_data2, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {cfg_ready2, cfg_ready1}, 2'b11);

        // well-formed two-predicate packet
        pk = {hdr(1'b1, 4'd2, 32'hAAAA_AAAA), 64'hAAAA_AAAA_AAAA_AAAA, 64'h111, 64'h222};
        send(pk);
        collect("p1", 0);

        // three predicates: overflows both depths
        pk = {hdr(1'b0, 4'd3, 32'h1234_5678), 64'h0BAD_F00D_CAFE_0001, 64'h333, 64'h444, 64'hFFFF_0000_0000_0555};
        send(pk);
        collect("p2", 0);

        // last arrives on first predicate of two
        pk = {hdr(1'b1, 4'd2, 32'h0000_00C3), 64'h5555_6666_7777_8888, 64'h0000_ABCD_EF01_2345};
        send(pk);
        collect("p3", 0);

        // count=0, meta only; downstream stalls for 20 cycles
        pk = {hdr(1'b0, 4'd0, 32'hDEAD_BEEF), 64'h0123_4567_89AB_CDEF};
        send(pk);
        collect("p4", 20);

        // count reached early, extra beat discarded
        pk = {hdr(1'b1, 4'd1, 32'h0F0F_0F0F), 64'h1111_2222_3333_4444, 64'h7777_8888_9999, 64'hAAAA_BBBB_CCCC};
        send(pk);
        collect("p5", 0);

        // count field beyond the maximum
        pk = {hdr(1'b0, 4'd12, 32'h8000_0001), 64'h2, 64'h1_0000_0001, 64'hFFFF_FFFF_FFFF};
        send(pk);
        collect("p6", 0);

        // reset while predicates are streaming in
        drive_beat(hdr(1'b1, 4'd2, 32'h5A5A_5A5A), 1'b0);
        drive_beat(64'h9999_9999_9999_9999, 1'b0);
        drive_beat(64'hBEEF, 1'b0);
        @(negedge clk);
        cfg_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pkts_exp = 0;
        errs2_exp = 0;
        errs1_exp = 0;
        chk("rst_mid_clean", {pred_valid2, pred_valid1, error_input2}, 3'b000);
        chk("rst_mid_data", pred_data2, '0);
        pk = {hdr(1'b0, 4'd1, 32'h0000_0042), 64'h0000_0000_0000_0099, 64'h4242_4242_4242};
        send(pk);
        collect("p7", 0);

        pk = {hdr(1'b0, 4'd2, 32'h7654_3210), 64'hFEDC_BA98_7654_3210, 64'h0000_0000_0001, 64'h8000_0000_0000};
        send(pk);
        collect("p8", 0);

        pk = {hdr(1'b1, 4'd1, 32'h1357_9BDF), 64'h2468_ACE0_2468_ACE0, 64'hC001_D00D_0123};
        send(pk);
        collect("p9", 0);

        pk = {hdr(1'b0, 4'd3, 32'h0000_0003), 64'h3, 64'h1, 64'h2};
        send(pk);
        collect("p10", 0);

`ifdef NUKV_PRED_ASM_STATS_EN
        chk("stat_pkts", {stat_pkts2, stat_pkts1}, {pkts_exp[31:0], pkts_exp[31:0]});
        chk("stat_errs", {stat_errs2, stat_errs1}, {errs2_exp[31:0], errs1_exp[31:0]});
`else
        chk("stat_pkts", {stat_pkts2, stat_pkts1}, 64'd0);
        chk("stat_errs", {stat_errs2, stat_errs1}, 64'd0);
`endif
        chk("sb_drained", W'(sb.size()), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
